// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg: shared constants and the one-cold anode encoder for bcd_scan_mux
package bcd_scan_pkg;
    localparam logic [3:0] BCD_BLANK_ZERO = 4'd0;
    function automatic logic [7:0] onehot_cold(input logic [2:0] sel, input int n);
        logic [7:0] r;
        r = '1;
        for (int i = 0; i < 8; i++) r[i] = !(i == int'(sel) && i < n);
        return r;
    endfunction
endpackage

// File: rtl/bcd_scan_mux_scan_timer.sv
// scan_timer: tick/slot/frame counters; frame_start is registered to line up with the first slot-0 output
module scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int REFRESH_TICKS = 2**19,
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic reset,
    output logic [$clog2(NUM_DIGITS)-1:0] slot,
    output logic slot_change,
    output logic frame_start,
    output logic blink_phase
);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(REFRESH_TICKS);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [TW-1:0] tick;
    logic [FW-1:0] frame_cnt;
    logic frame_end, frame_last;
    assign slot_change = tick == TW'(REFRESH_TICKS - 1);
    assign frame_end = slot_change && slot == SW'(NUM_DIGITS - 1);
    assign frame_last = frame_cnt == FW'(BLINK_FRAMES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
            slot <= '0;
            frame_cnt <= '0;
            blink_phase <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            tick <= slot_change ? '0 : tick + 1'b1;
            if (slot_change) slot <= frame_end ? '0 : slot + 1'b1;
            frame_start <= slot == '0 && tick == '0;
            if (frame_end) frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
            if (frame_end && frame_last) blink_phase <= !blink_phase;
        end
    end
endmodule

// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux: multiplexed 7-segment digit driver with frame-synchronous loads, LZ blanking, blink and PWM dimming
module bcd_scan_mux
    import bcd_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int REFRESH_TICKS = 2**19,
    parameter int BRIGHT_BITS = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic [NUM_DIGITS-1:0] blink_mask_in,
    input  logic load,
    input  logic blank_lz,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [3:0] output_number,
    output logic dp_out,
    output logic [NUM_DIGITS-1:0] digit_select,
    output logic frame_start
);
    localparam int SW = $clog2(NUM_DIGITS);
    logic [SW-1:0] slot;
    logic slot_change, blink_phase, frame_end, pending, run, blank, lit;
    logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
    logic [NUM_DIGITS-1:0] sh_dp, act_dp, sh_blink, act_blink, lz, cold;
    logic [BRIGHT_BITS-1:0] pwm_cnt;
    scan_timer #(
        .NUM_DIGITS(NUM_DIGITS),
        .REFRESH_TICKS(REFRESH_TICKS),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .slot(slot),
        .slot_change(slot_change),
        .frame_start(frame_start),
        .blink_phase(blink_phase)
    );
    assign frame_end = slot_change && slot == SW'(NUM_DIGITS - 1);
    assign cold = NUM_DIGITS'(onehot_cold(3'(slot), NUM_DIGITS));
    // A digit is a leading zero only if it and every more significant digit is a dp-less zero
    always_comb begin
        lz = '0;
        run = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run = run && act_digits[4*i +: 4] == BCD_BLANK_ZERO && !act_dp[i];
            lz[i] = run;
        end
        blank = lz[slot] || (blink_phase && act_blink[slot]);
        lit = !blank && (&brightness || pwm_cnt < brightness);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_digits <= '0;
            sh_dp <= '0;
            sh_blink <= '0;
            act_digits <= '0;
            act_dp <= '0;
            act_blink <= '0;
            pending <= 1'b0;
            pwm_cnt <= '0;
            output_number <= '0;
            dp_out <= 1'b0;
            digit_select <= '1;
        end else begin
            if (load) begin
                sh_digits <= digits_in;
                sh_dp <= dp_in;
                sh_blink <= blink_mask_in;
            end
            if (frame_end && pending) begin
                act_digits <= sh_digits;
                act_dp <= sh_dp;
                act_blink <= sh_blink;
            end
            pending <= load || (pending && !frame_end);
            pwm_cnt <= slot_change ? '0 : pwm_cnt + 1'b1;
            output_number <= act_digits[{slot, 2'b00} +: 4];
            dp_out <= lit && act_dp[slot];
            digit_select <= lit ? cold : '1;
        end
    end
endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb_bcd_scan_mux: directed checks of scan order, load sync, LZ, blink, PWM and reset
module tb_bcd_scan_mux;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0] dp_in = '0;
    logic [3:0] blink_mask_in = '0;
    logic load = 1'b0;
    logic blank_lz = 1'b0;
    logic [1:0] brightness = 2'd3;
    logic [3:0] output_number, digit_select;
    logic dp_out, frame_start;
    int k, n_cmp, n_bad;
    bcd_scan_mux #(
        .NUM_DIGITS(4),
        .REFRESH_TICKS(8),
        .BRIGHT_BITS(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .blink_mask_in(blink_mask_in),
        .load(load),
        .blank_lz(blank_lz),
        .brightness(brightness),
        .output_number(output_number),
        .dp_out(dp_out),
        .digit_select(digit_select),
        .frame_start(frame_start)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (k=%0d): got %0h, expected %0h", tag, k, got, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
        k++;
    endtask
    task automatic run_to(input int t);
        while (k < t) step();
    endtask
    function automatic logic [3:0] sel(input int s);
        return ~(4'b0001 << s);
    endfunction
    function automatic logic [3:0] nib(input logic [15:0] v, input int s);
        return 4'((v >> (4 * s)) & 16'hF);
    endfunction
    task automatic do_reset();
        reset = 1'b1;
        load = 1'b0;
        @(negedge clk);
        check("rst_sel", 32'(digit_select), 32'hF);
        check("rst_num", 32'(output_number), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = -1;
    endtask
    task automatic load_word(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
        digits_in = d;
        dp_in = dp;
        blink_mask_in = bm;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        n_cmp = 0;
        n_bad = 0;
        k = 0;
        do_reset();
        repeat (64) begin
            step();
            check("scan_sel", 32'(digit_select), 32'(sel((k / 8) % 4)));
            check("scan_fs", 32'(frame_start), 32'(k % 32 == 0));
        end
        do_reset();
        run_to(10);
        load_word(16'h1234, 4'h0, 4'h0);
        run_to(16); check("old_s2", 32'(output_number), 32'h0);
        run_to(31); check("old_s3", 32'(output_number), 32'h0);
        for (int s = 0; s < 4; s++) begin
            run_to(32 + 8 * s);
            check("new_num", 32'(output_number), 32'(nib(16'h1234, s)));
            check("new_sel", 32'(digit_select), 32'(sel(s)));
        end
        run_to(70);
        load_word(16'h5678, 4'h0, 4'h0);
        run_to(80);
        load_word(16'h0987, 4'h0, 4'h0);
        run_to(96); check("two_fs", 32'(frame_start), 32'h1);
        for (int s = 0; s < 4; s++) begin
            run_to(96 + 8 * s);
            check("two_num", 32'(output_number), 32'(nib(16'h0987, s)));
        end
        run_to(126);
        load_word(16'h4321, 4'h0, 4'h0);
        run_to(128); check("bnd_old", 32'(output_number), 32'h7);
        run_to(160); check("bnd_new", 32'(output_number), 32'h1);
        do_reset();
        blank_lz = 1'b1;
        step();
        load_word(16'h0050, 4'h0, 4'h0);
        run_to(32); check("lz_s0_sel", 32'(digit_select), 32'hE);
        check("lz_s0_num", 32'(output_number), 32'h0);
        run_to(40); check("lz_s1_sel", 32'(digit_select), 32'hD);
        check("lz_s1_num", 32'(output_number), 32'h5);
        run_to(48); check("lz_s2_sel", 32'(digit_select), 32'hF);
        check("lz_s2_dp", 32'(dp_out), 32'h0);
        run_to(56); check("lz_s3_sel", 32'(digit_select), 32'hF);
        run_to(60);
        load_word(16'h0050, 4'h4, 4'h0);
        run_to(80); check("lzdp_s2_sel", 32'(digit_select), 32'hB);
        check("lzdp_s2_dp", 32'(dp_out), 32'h1);
        run_to(88); check("lzdp_s3_sel", 32'(digit_select), 32'hF);
        blank_lz = 1'b0;
        do_reset();
        step();
        load_word(16'h0000, 4'h0, 4'h1);
        for (int f = 1; f < 6; f++) begin
            run_to(32 * f);
            check("blink_s0", 32'(digit_select), (f == 2 || f == 3) ? 32'hF : 32'hE);
        end
        run_to(200);
        brightness = 2'd1;
        do_reset();
        run_to(8);
        repeat (8) begin
            check("pwm1", 32'(digit_select), (k % 4 == 0) ? 32'hD : 32'hF);
            step();
        end
        brightness = 2'd0;
        run_to(17);
        repeat (32) begin
            check("pwm0", 32'(digit_select), 32'hF);
            step();
        end
        brightness = 2'd3;
        do_reset();
        step();
        load_word(16'h12CA, 4'h0, 4'h0);
        run_to(32); check("pass_hex", 32'(output_number), 32'hA);
        run_to(50); check("mid_s2", 32'(output_number), 32'h2);
        run_to(52);
        load_word(16'h5555, 4'h0, 4'h0);
        do_reset();
        step();
        check("mr_sel", 32'(digit_select), 32'hE);
        check("mr_num", 32'(output_number), 32'h0);
        check("mr_fs", 32'(frame_start), 32'h1);
        run_to(32); check("mr_pend", 32'(output_number), 32'h0);
        run_to(40); check("mr_pend1", 32'(output_number), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
